imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the instruction RAM depth in words (2**ADDR_W).
REQ-002 SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  a one-cycle request to begin a program load.
REQ-005 SHALL have port rx_data  input  8  the serial program byte.
REQ-006 SHALL have port rx_valid  input  1  indicating that rx_data is valid.
REQ-007 SHALL have port rx_ready  output  1  indicating the loader accepts a byte; a byte transfers when rx_valid and rx_ready are both 1.
REQ-008 SHALL have port mem_we  output  1  the instruction RAM write strobe.
REQ-009 SHALL have port mem_addr  output  32  the byte address, word-aligned, in the same address space as the fetch PC.
REQ-010 SHALL have port mem_wdata  output  32  the instruction word to write.
REQ-011 SHALL have port cpu_hold  output  1  which holds the pipeline stalled with PC at 0 while loading.
REQ-012 SHALL have port busy  output  1  which is high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  a one-cycle pulse on successful completion.
REQ-014 SHALL have port err  output  1  a sticky flag indicating a length-overflow error.

Function
REQ-015 SHALL implement the states IDLE, HDR0, HDR1, LOAD, DONE and ERR.
REQ-016 SHALL move from IDLE to HDR0 on start; start SHALL be ignored in every other state except ERR.
REQ-017 SHALL assert rx_ready only in HDR0, HDR1 and LOAD; rx_ready SHALL not depend combinationally on rx_valid.
REQ-018 SHALL take header byte 0 as count[7:0] (HDR0 to HDR1) and header byte 1 as count[15:8].
REQ-019 SHALL, on HDR1 acceptance, go to DONE if count==0, go to ERR if count>2**ADDR_W, and otherwise go to LOAD with word index 0.
REQ-020 SHALL, in LOAD, assemble bytes little-endian: the first byte goes to word[7:0] and the fourth to word[31:24].
REQ-021 SHALL assert mem_we for exactly one cycle, in the cycle after the fourth byte is accepted, with mem_wdata=word and mem_addr=4*index; index SHALL then increment.
REQ-022 SHALL keep accepting bytes during a mem_we cycle (zero-bubble streaming at one byte per cycle).
REQ-023 SHALL go from LOAD to DONE in the same cycle that the mem_we for word index count-1 is issued.
REQ-024 SHALL hold DONE for one cycle, with done=1 and cpu_hold=1, then return to IDLE with cpu_hold=0.
REQ-025 SHALL, in ERR, set err=1, cpu_hold=1 and rx_ready=0, and issue no writes; err SHALL clear only on start, which SHALL move to HDR0.
REQ-026 SHALL keep cpu_hold=1 from the cycle after start through the DONE cycle.
REQ-027 SHALL leave bytes with rx_valid=0 unconsumed and keep the partial word; stalls of any length SHALL be tolerated.
REQ-028 SHALL drive mem_addr and mem_wdata to 0 whenever mem_we=0.
REQ-029 SHALL keep index at ADDR_W+1 bits, so that no wrap occurs at count=2**ADDR_W, and the last address SHALL be 4*(2**ADDR_W-1).

Reset
REQ-030 SHALL, on reset, set state to IDLE, and set index, the byte counter, the partial word, mem_we, done, err, busy, cpu_hold and rx_ready to 0.
REQ-031 SHALL, on reset mid-load, abort immediately with no write of a partial word; start in the same cycle as reset SHALL be ignored.

Structure
REQ-032 SHALL define the state enum and the header length (2 bytes) in a shared package, imem_pkg.
REQ-033 SHALL place byte-to-word assembly (byte counter, shift register, word_valid pulse) in the sub-module imem_word_packer, and keep the FSM and index in imem_loader.

Verification
REQ-034 SHALL verify: start, then bytes 02 00 83 A2 C4 FF 33 E2 62 00 -> mem_we at 0x0000 with 0xFFC4A283 and at 0x0004 with 0x0062E233, done one cycle after the second write, and cpu_hold falling the next cycle.
REQ-035 SHALL verify: header 00 00 -> DONE directly, done=1, and no mem_we.
REQ-036 SHALL verify: with ADDR_W=10, header 01 04 (count 1025) -> err=1, rx_ready=0 and no writes; a following start clears err.
REQ-037 SHALL verify: a random rx_valid gap pattern over 8 words -> identical writes and addresses 0x00 to 0x1C.
REQ-038 SHALL verify: reset asserted after 2 bytes of word 3 -> all outputs 0 next cycle and only words 0 to 2 written.
REQ-039 SHALL verify: start pulsed during LOAD -> ignored, with index and count unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Holds the loader state encoding and the framing constants.
// Imported by imem_loader and imem_word_packer.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    LOAD,
    DONE,
    ERR
  } state_t;

  // Header is a 16-bit little-endian word count.
  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a stream of bytes little-endian into 32-bit words.
// Latency: word_valid pulses one cycle after the fourth byte is taken.
// Backpressure: none internally; the caller gates in_vld with its own ready.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_vld,
  input  logic [7:0]  in_dat,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] byte_cnt;

  // Shift bytes in from the top so the first byte ends up in word[7:0].
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt   <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= in_vld && last_byte;
      if (in_vld) begin
        word     <= {in_dat, word[31:8]};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  // High while the next accepted byte completes a word.
  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: 2-byte length header then little-endian words into IMEM.
// Latency: each word is written one cycle after its fourth byte; done one cycle after the last write.
// Backpressure: rx_ready is a registered function of state only; stalls on rx_valid=0 are unbounded.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t            state;
  logic [15:0]       count;
  logic [ADDR_W:0]   index;

  logic              accept;
  logic              pk_vld;
  logic              pk_last_byte;
  logic              pk_word_valid;
  logic [31:0]       pk_word;
  logic [15:0]       hdr_count;
  logic [16:0]       idx_ext;
  logic [16:0]       last_idx;
  logic              last_word;

  assign accept    = rx_valid && rx_ready;
  assign pk_vld    = accept && (state == LOAD);
  assign hdr_count = {rx_data, count[7:0]};
  assign idx_ext   = 17'(index);
  assign last_idx  = {1'b0, count} - 17'd1;
  assign last_word = (idx_ext == last_idx);

  // The packer is held empty outside LOAD so a restart never sees stale bytes.
  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != LOAD),
    .in_vld     (pk_vld),
    .in_dat     (rx_data),
    .last_byte  (pk_last_byte),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  // Loader FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 16'd0;
      index    <= '0;
      rx_ready <= 1'b0;
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR0;
            rx_ready <= 1'b1;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
          end
        end
        HDR0: begin
          if (accept) begin
            count[7:0] <= rx_data;
            state      <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            count[15:8] <= rx_data;
            index       <= '0;
            if (hdr_count == 16'd0) begin
              state    <= DONE;
              rx_ready <= 1'b0;
              done     <= 1'b1;
            end else if ({1'b0, hdr_count} > DEPTH) begin
              state    <= ERR;
              rx_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          // Stop taking bytes once the final byte of the program is in.
          if (accept && pk_last_byte && last_word) begin
            rx_ready <= 1'b0;
          end
          if (pk_word_valid) begin
            index <= index + 1'b1;
            if (last_word) begin
              state    <= DONE;
              rx_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        ERR: begin
          if (start) begin
            state    <= HDR0;
            err      <= 1'b0;
            rx_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write port is quiet (all zero) except during the single write cycle.
  assign mem_we    = pk_word_valid && (state == LOAD);
  assign mem_addr  = mem_we ? {{(30 - ADDR_W){1'b0}}, index[ADDR_W-1:0], 2'b00} : 32'd0;
  assign mem_wdata = mem_we ? pk_word : 32'd0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with a write-port monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int idle_bad = 0;
  int done_cyc = -1;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  imem_loader #(.ADDR_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write and any non-zero address/data outside a write cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end else if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      idle_bad++;
    end
    if (done === 1'b1) done_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc = -1;
  endtask

  // Present a byte and return right after the edge that transfers it; rx_valid stays high.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (rx_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte_timeout rx_ready=%b want 1", rx_ready);
    end else begin
      tick();
    end
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick();
    n_cmp++;
    if ({rx_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl got=%b want=000000", {rx_ready, mem_we, cpu_hold, busy, done, err});
    end
    n_cmp++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_bus addr=%h data=%h want 0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] b[10] = '{8'h02, 8'h00, 8'h83, 8'hA2, 8'hC4, 8'hFF, 8'h33, 8'hE2, 8'h62, 8'h00};
    clear_log();
    pulse_start();
    n_cmp++;
    if ({busy, cpu_hold, rx_ready} !== 3'b111) begin
      n_bad++;
      $display("FAIL basic_after_start busy/hold/ready=%b want 111", {busy, cpu_hold, rx_ready});
    end
    for (int i = 0; i < 10; i++) send_byte(b[i]);
    rx_valid = 1'b0;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h4, 32'h0062E233}) begin
      n_bad++;
      $display("FAIL basic_last_write we=%b addr=%h data=%h want 1/00000004/0062e233", mem_we, mem_addr, mem_wdata);
    end
    tick();
    n_cmp++;
    if ({done, cpu_hold, mem_we} !== 3'b110) begin
      n_bad++;
      $display("FAIL basic_done done/hold/we=%b want 110", {done, cpu_hold, mem_we});
    end
    tick();
    n_cmp++;
    if ({done, cpu_hold, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL basic_release done/hold/busy=%b want 000", {done, cpu_hold, busy});
    end
    n_cmp++;
    if (wr_addr.size() != 2) begin
      n_bad++;
      $display("FAIL basic_nwrites got=%0d want=2", wr_addr.size());
    end else begin
      n_cmp++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hFFC4A283) begin
        n_bad++;
        $display("FAIL basic_w0 addr=%h data=%h want 00000000/ffc4a283", wr_addr[0], wr_data[0]);
      end
      n_cmp++;
      if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0062E233) begin
        n_bad++;
        $display("FAIL basic_w1 addr=%h data=%h want 00000004/0062e233", wr_addr[1], wr_data[1]);
      end
      n_cmp++;
      if (wr_cyc[1] - wr_cyc[0] != 4) begin
        n_bad++;
        $display("FAIL basic_stream_gap got=%0d want=4", wr_cyc[1] - wr_cyc[0]);
      end
      n_cmp++;
      if (done_cyc != wr_cyc[1] + 1) begin
        n_bad++;
        $display("FAIL basic_done_timing got=%0d want=%0d", done_cyc, wr_cyc[1] + 1);
      end
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    rx_valid = 1'b0;
    n_cmp++;
    if ({done, cpu_hold, rx_ready} !== 3'b110) begin
      n_bad++;
      $display("FAIL zero_done done/hold/ready=%b want 110", {done, cpu_hold, rx_ready});
    end
    tick();
    n_cmp++;
    if ({done, cpu_hold, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL zero_release done/hold/busy=%b want 000", {done, cpu_hold, busy});
    end
    n_cmp++;
    if (wr_addr.size() != 0) begin
      n_bad++;
      $display("FAIL zero_nwrites got=%0d want=0", wr_addr.size());
    end
  endtask

  task automatic test_overflow();
    clear_log();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h04);
    rx_valid = 1'b0;
    n_cmp++;
    if ({err, rx_ready, cpu_hold, busy} !== 4'b1011) begin
      n_bad++;
      $display("FAIL ovf_enter err/ready/hold/busy=%b want 1011", {err, rx_ready, cpu_hold, busy});
    end
    rx_data = 8'hAA; rx_valid = 1'b1;
    repeat (6) tick();
    rx_valid = 1'b0;
    n_cmp++;
    if ({err, rx_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL ovf_sticky err/ready=%b want 10", {err, rx_ready});
    end
    n_cmp++;
    if (wr_addr.size() != 0) begin
      n_bad++;
      $display("FAIL ovf_nwrites got=%0d want=0", wr_addr.size());
    end
    pulse_start();
    n_cmp++;
    if ({err, rx_ready, busy} !== 3'b011) begin
      n_bad++;
      $display("FAIL ovf_restart err/ready/busy=%b want 011", {err, rx_ready, busy});
    end
    send_byte(8'h00);
    send_byte(8'h00);
    rx_valid = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_back_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_gaps();
    int gap[32] = '{0, 3, 1, 0, 2, 0, 0, 5, 1, 1, 0, 4, 0, 2, 7, 0,
                    1, 0, 0, 3, 2, 0, 1, 0, 6, 0, 0, 1, 3, 0, 2, 1};
    logic [7:0] b[32];
    logic [31:0] exp_w;
    bit ok;
    for (int k = 0; k < 32; k++) b[k] = 8'((k * 37 + 11) & 255);
    clear_log();
    pulse_start();
    send_byte(8'h08);
    send_byte(8'h00);
    for (int k = 0; k < 32; k++) begin
      if (gap[k] > 0) begin
        rx_valid = 1'b0;
        repeat (gap[k]) tick();
      end
      send_byte(b[k]);
    end
    rx_valid = 1'b0;
    wait_done(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL gaps_done_timeout done=%b want 1", done);
    end
    tick();
    n_cmp++;
    if (wr_addr.size() != 8) begin
      n_bad++;
      $display("FAIL gaps_nwrites got=%0d want=8", wr_addr.size());
    end
    for (int j = 0; j < 8 && j < wr_addr.size(); j++) begin
      exp_w = {b[4*j+3], b[4*j+2], b[4*j+1], b[4*j]};
      n_cmp++;
      if (wr_addr[j] !== 32'(4 * j) || wr_data[j] !== exp_w) begin
        n_bad++;
        $display("FAIL gaps_w%0d addr=%h data=%h want %h/%h", j, wr_addr[j], wr_data[j], 32'(4 * j), exp_w);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h00);
    for (int k = 0; k < 14; k++) send_byte(8'(k + 1));
    rx_valid = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    tick();
    n_cmp++;
    if ({rx_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0) begin
      n_bad++;
      $display("FAIL rstmid_ctrl got=%b want=000000", {rx_ready, mem_we, cpu_hold, busy, done, err});
    end
    n_cmp++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_bad++;
      $display("FAIL rstmid_bus addr=%h data=%h want 0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_start_ignored busy=%b want 0", busy);
    end
    n_cmp++;
    if (wr_addr.size() != 3) begin
      n_bad++;
      $display("FAIL rstmid_nwrites got=%0d want=3", wr_addr.size());
    end else begin
      n_cmp++;
      if (wr_addr[0] !== 32'h0 || wr_addr[1] !== 32'h4 || wr_addr[2] !== 32'h8) begin
        n_bad++;
        $display("FAIL rstmid_addrs got=%h,%h,%h want 0,4,8", wr_addr[0], wr_addr[1], wr_addr[2]);
      end
      n_cmp++;
      if (wr_data[2] !== 32'h0C0B0A09) begin
        n_bad++;
        $display("FAIL rstmid_w2 data=%h want 0c0b0a09", wr_data[2]);
      end
    end
  endtask

  task automatic test_start_in_load();
    logic [7:0] b[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bit ok;
    clear_log();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(b[0]);
    send_byte(b[1]);
    rx_valid = 1'b0;
    pulse_start();
    n_cmp++;
    if ({busy, cpu_hold, rx_ready, err} !== 4'b1110) begin
      n_bad++;
      $display("FAIL sil_state busy/hold/ready/err=%b want 1110", {busy, cpu_hold, rx_ready, err});
    end
    for (int k = 2; k < 8; k++) send_byte(b[k]);
    rx_valid = 1'b0;
    wait_done(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL sil_done_timeout done=%b want 1", done);
    end
    tick();
    n_cmp++;
    if (wr_addr.size() != 2) begin
      n_bad++;
      $display("FAIL sil_nwrites got=%0d want=2", wr_addr.size());
    end else begin
      n_cmp++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h44332211 ||
          wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h88776655) begin
        n_bad++;
        $display("FAIL sil_writes %h:%h %h:%h want 0:44332211 4:88776655",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
  endtask

  task automatic test_idle_zero();
    n_cmp++;
    if (idle_bad != 0) begin
      n_bad++;
      $display("FAIL idle_bus_nonzero got=%0d cycles want=0", idle_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_gaps();
    test_reset_mid();
    test_start_in_load();
    test_idle_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
